// File: rtl/conv_sequencer.sv
// conv_sequencer: debounces a pushbutton, latches a 4-bit switch code into the
// code converter, holds ready for a settle time, then captures and holds the
// converter result. It also counts completed conversions, saturating at full scale.
module conv_sequencer #(
    parameter int DEB_CYCLES    = 250000,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn,
    input  logic [3:0]       sw_code,
    input  logic [3:0]       conv_S,
    output logic             conv_A,
    output logic             conv_B,
    output logic             conv_C,
    output logic             conv_D,
    output logic             conv_ready,
    output logic [3:0]       result,
    output logic             valid,
    output logic             busy,
    output logic [CNT_W-1:0] conv_count
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, HOLD} state_t;

    logic             sync_q, btn_s, deb, deb_q, req;
    logic [DEB_W-1:0] deb_cnt;

    state_t           state, state_n;
    logic [3:0]       conv_code, code_n;
    logic             ready_n, valid_n;
    logic [3:0]       result_n;
    logic [CNT_W-1:0] count_n;
    logic [SET_W-1:0] settle_cnt, settle_n;

    // Synchronize the raw button, then accept a level only after DEB_CYCLES
    // consecutive samples that differ from the current debounced level.
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= 1'b0;
            btn_s   <= 1'b0;
            deb     <= 1'b0;
            deb_q   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync_q <= btn;
            btn_s  <= sync_q;
            deb_q  <= deb;
            if (btn_s == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // One-cycle request on the rising edge of the debounced level.
    assign req = deb & ~deb_q;

    // Next-state and next-output logic for the conversion sequence.
    // NOTE: every signal gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_n  = state;
        code_n   = conv_code;
        ready_n  = conv_ready;
        valid_n  = valid;
        result_n = result;
        count_n  = conv_count;
        settle_n = settle_cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    code_n  = sw_code;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                ready_n  = 1'b1;
                valid_n  = 1'b0;
                settle_n = '0;
                state_n  = SETTLE;
            end
            SETTLE: begin
                settle_n = settle_cnt + 1'b1;
                if (settle_cnt == SET_LAST) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                result_n = conv_S;
                valid_n  = 1'b1;
                ready_n  = 1'b0;
                if (conv_count != '1) begin
                    count_n = conv_count + 1'b1;
                end
                state_n = HOLD;
            end
            HOLD: begin
                // One conversion per press: wait for a debounced release.
                if (!deb) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset wins over any in-flight conversion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            conv_code  <= '0;
            conv_ready <= 1'b0;
            valid      <= 1'b0;
            result     <= '0;
            conv_count <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_n;
            conv_code  <= code_n;
            conv_ready <= ready_n;
            valid      <= valid_n;
            result     <= result_n;
            conv_count <= count_n;
            settle_cnt <= settle_n;
        end
    end

    assign {conv_A, conv_B, conv_C, conv_D} = conv_code;
    assign busy = (state == LOAD) || (state == SETTLE) || (state == CAPTURE);

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: scoreboard bench for conv_sequencer with a small
// converter model (S = code * 3 mod 16) attached to the converter port.
module tb_conv_sequencer;

    localparam int DEB   = 4;
    localparam int SET   = 2;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          btn;
    logic [3:0]    sw_code;
    logic [3:0]    conv_S;
    logic          conv_A, conv_B, conv_C, conv_D;
    logic          conv_ready;
    logic [3:0]    result;
    logic          valid;
    logic          busy;
    logic [CW-1:0] conv_count;

    typedef struct {
        logic [3:0] code;
        logic [3:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   n_conv    = 0;
    int   n_busy    = 0;
    int   busy_cyc  = 0;
    int   ready_len = 0;
    int   exp_count = 0;
    logic busy_q = 1'b0, ready_q = 1'b0, valid_q = 1'b0;

    conv_sequencer #(
        .DEB_CYCLES(DEB), .SETTLE_CYCLES(SET), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .sw_code(sw_code), .conv_S(conv_S),
        .conv_A(conv_A), .conv_B(conv_B), .conv_C(conv_C), .conv_D(conv_D),
        .conv_ready(conv_ready), .result(result), .valid(valid), .busy(busy),
        .conv_count(conv_count)
    );

    function automatic logic [3:0] conv_model(input logic [3:0] x);
        return x * 4'd3;
    endfunction

    assign conv_S = conv_model({conv_A, conv_B, conv_C, conv_D});

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pulse width of ready, latency, and scoreboard pop on valid rise.
    always @(negedge clk) begin
        if (!reset) begin
            ready_len = 0;
        end else begin
            if (busy && !busy_q) begin
                busy_cyc = cyc;
                n_busy++;
            end
            if (conv_ready) begin
                ready_len++;
            end else if (ready_q) begin
                check("ready_width", ready_len, SET + 1);
                ready_len = 0;
            end
            if (valid && !valid_q) begin
                n_conv++;
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    if (exp_count < CMAX) exp_count++;
                    check("result", result, e.res);
                    check("conv_code", {conv_A, conv_B, conv_C, conv_D}, e.code);
                    check("conv_count", conv_count, exp_count);
                    check("latency", cyc - busy_cyc, SET + 2);
                end
            end
        end
        busy_q  = busy;
        ready_q = conv_ready;
        valid_q = valid;
    end

    task automatic do_reset();
        reset = 1'b0;
        btn   = 1'b0;
        tick(2);
        sb.delete();
        exp_count = 0;
        reset = 1'b1;
        tick(2);
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        sw_code = code;
        sb.push_back('{code, conv_model(code)});
        btn = 1'b1;
        tick(hold);
        btn = 1'b0;
        tick(12);
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget && !conv_ready; i++) tick(1);
        check("ready_seen", conv_ready, 1);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Reset held with the button pressed: everything cleared.
        reset   = 1'b0;
        btn     = 1'b1;
        sw_code = 4'b1010;
        tick(3);
        check("rst_code", {conv_A, conv_B, conv_C, conv_D}, 0);
        check("rst_ready", conv_ready, 0);
        check("rst_result", result, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", conv_count, 0);
        btn   = 1'b0;
        reset = 1'b1;
        tick(15);
        check("rst_no_conv", n_conv, 0);

        // Basic conversion: 0011 -> 1001.
        base = n_conv;
        press(4'b0011, 20);
        check("basic_convs", n_conv - base, 1);
        check("basic_valid_held", valid, 1);
        check("basic_result_held", result, 4'b1001);
        check("basic_count", conv_count, 1);

        // Bounce and short presses produce no request; a stable press does.
        do_reset();
        base = n_busy;
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1; tick(2);
            btn = 1'b0; tick(2);
        end
        btn = 1'b1; tick(3);
        check("bounce_no_req", n_busy - base, 0);
        btn = 1'b0; tick(10);
        check("short_press_no_req", n_busy - base, 0);
        base = n_conv;
        sw_code = 4'b0101;
        sb.push_back('{4'b0101, conv_model(4'b0101)});
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1; tick(2);
            btn = 1'b0; tick(2);
        end
        btn = 1'b1; tick(20);
        btn = 1'b0; tick(12);
        check("bounce_one_conv", n_conv - base, 1);
        check("bounce_count", conv_count, 1);

        // Switch change during SETTLE does not reach the result.
        do_reset();
        base = n_conv;
        sw_code = 4'b0011;
        sb.push_back('{4'b0011, conv_model(4'b0011)});
        btn = 1'b1;
        wait_ready(40);
        tick(1);
        sw_code = 4'b1111;
        tick(20);
        btn = 1'b0;
        tick(12);
        check("stable_result", result, 4'b1001);
        press(4'b1111, 20);
        check("stable_new_code", {conv_A, conv_B, conv_C, conv_D}, 4'b1111);
        check("stable_convs", n_conv - base, 2);

        // Long hold gives one conversion; counter saturates at 3.
        do_reset();
        base = n_conv;
        press(4'b0110, 100);
        check("held_one_conv", n_conv - base, 1);
        for (int i = 0; i < 4; i++) press(4'(i + 7), 20);
        check("sat_convs", n_conv - base, 5);
        check("sat_count", conv_count, CMAX);
        check("sb_drained", sb.size(), 0);

        // Reset during SETTLE: outputs clear on that edge and nothing is captured.
        do_reset();
        base = n_conv;
        sw_code = 4'b1001;
        btn = 1'b1;
        wait_ready(40);
        tick(1);
        reset = 1'b0;
        tick(1);
        check("mid_rst_ready", conv_ready, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_count", conv_count, 0);
        check("mid_rst_busy", busy, 0);
        tick(1);
        btn   = 1'b0;
        reset = 1'b1;
        tick(15);
        check("mid_rst_no_conv", n_conv - base, 0);
        check("mid_rst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
